// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver and its surroundings: baud tick and
// serial line in, received word and status pulses out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_tick;
  logic                 i_rx;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_rx_done;
  logic                 o_frame_error;
  logic                 o_parity_error;
  logic                 o_busy;

  modport slave (
    input  i_tick, i_rx,
    output o_data, o_rx_done, o_frame_error, o_parity_error, o_busy
  );

  modport master (
    output i_tick, i_rx,
    input  o_data, o_rx_done, o_frame_error, o_parity_error, o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start, DATA_BITS LSB-first data bits, one stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int DATA_BITS     = 8,
  parameter int TICKS_PER_BIT = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic     i_clock,
  input  logic     i_reset,
  uart_rx_if.slave bus
);
  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  state_t                 state_q;
  logic [TW-1:0]          tick_q;
  logic [BW-1:0]          bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   done_q;
  logic                   ferr_q;
  logic                   busy_q;
`ifdef UART_RX_PARITY_EN
  logic                   par_err_q;
  logic                   perr_q;
`else
  localparam logic        par_err_q = 1'b0;
  localparam logic        perr_q    = 1'b0;
`endif

  // Synchronizer presets to the idle level so reset never looks like a start bit
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      if (bus.i_tick) begin
        case (state_q)
          S_IDLE: begin
            if (!rx_s) begin
              state_q   <= S_START;
              tick_q    <= '0;
              busy_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
              par_err_q <= 1'b0;
`endif
            end
          end
          S_START: begin
            if (tick_q == TICK_MID) begin
              tick_q <= '0;
              bit_q  <= '0;
              if (!rx_s) begin
                state_q <= S_DATA;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          S_DATA: begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              bit_q   <= bit_q + 1'b1;
              if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (tick_q == TICK_LAST) begin
              tick_q    <= '0;
              par_err_q <= ^{shift_q, rx_s};
              state_q   <= S_STOP;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
`endif
          S_STOP: begin
            if (tick_q == TICK_LAST) begin
              tick_q <= '0;
`ifdef UART_RX_PARITY_EN
              perr_q <= par_err_q;
`endif
              if (rx_s) begin
                if (!par_err_q) begin
                  data_q <= shift_q;
                  done_q <= 1'b1;
                end
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= S_WAIT_IDLE;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          // A break holds us here so a stuck-low line is not read as 0x00 frames
          S_WAIT_IDLE: begin
            if (rx_s) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_data         = data_q;
  assign bus.o_rx_done      = done_q;
  assign bus.o_frame_error  = ferr_q;
  assign bus.o_parity_error = perr_q;
  assign bus.o_busy         = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clocks, 64 clocks per serial bit.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.DATA_BITS(8), .TICKS_PER_BIT(16), .SYNC_STAGES(2)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.i_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 bus.i_tick = 1'b1;
      @(posedge clk);
      #1 bus.i_tick = 1'b0;
    end
  end

  // Pulse monitor, sampled on the falling edge
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  logic       busy_at_done = 1'b1;
  logic [7:0] done_data [0:63];

  always @(negedge clk) begin
    if (bus.o_rx_done) begin
      if (done_cnt < 64) done_data[done_cnt] = bus.o_data;
      busy_at_done = bus.o_busy;
      done_cnt++;
    end
    if (bus.o_frame_error)  ferr_cnt++;
    if (bus.o_parity_error) perr_cnt++;
  end

  int d0, f0, p0;

  task automatic snap();
    d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_bit(input logic b);
    bus.i_rx = b;
    repeat (BIT_CLKS) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ pflip);
`else
    if (pflip) $display("note: parity flip ignored in 8N1 build");
`endif
    send_bit(stop);
  endtask

  task automatic idle(input int clks);
    bus.i_rx = 1'b1;
    repeat (clks) @(posedge clk);
    #2;
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] exp);
    chk({tag, "_done"}, 32'(done_cnt - d0), 1);
    chk({tag, "_data"}, {24'd0, done_data[d0]}, {24'd0, exp});
    chk({tag, "_ferr"}, 32'(ferr_cnt - f0), 0);
  endtask

  initial begin
    bus.i_rx = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_data", {24'd0, bus.o_data}, 0);
    chk("rst_busy", {31'd0, bus.o_busy}, 0);
    chk("rst_done", {31'd0, bus.o_rx_done}, 0);
    chk("rst_ferr", {31'd0, bus.o_frame_error}, 0);
    chk("rst_perr", {31'd0, bus.o_parity_error}, 0);
    rst = 1'b0;
    idle(2 * BIT_CLKS);

    // 1: basic 0xA5
    snap();
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        repeat (300) @(posedge clk);
        #1 chk("t1_busy_mid", {31'd0, bus.o_busy}, 1);
      end
    join
    idle(16);
    chk_frame("t1", 8'hA5);
    chk("t1_out", {24'd0, bus.o_data}, 32'hA5);
    chk("t1_busy_at_done", {31'd0, busy_at_done}, 0);
    chk("t1_perr", 32'(perr_cnt - p0), 0);

    // 2: start glitch of 4 ticks, then 0x3C
    snap();
    bus.i_rx = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    idle(2 * BIT_CLKS);
    chk("t2_glitch_done", 32'(done_cnt - d0), 0);
    chk("t2_glitch_ferr", 32'(ferr_cnt - f0), 0);
    chk("t2_glitch_busy", {31'd0, bus.o_busy}, 0);
    chk("t2_glitch_data", {24'd0, bus.o_data}, 32'hA5);
    snap();
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(16);
    chk_frame("t2", 8'h3C);

    // 3: framing error followed by a 40-tick break, then 0x81
    snap();
    send_frame(8'h5A, 1'b0, 1'b0);
    bus.i_rx = 1'b0;
    repeat (160) @(posedge clk);
    #2;
    idle(2 * BIT_CLKS);
    chk("t3_ferr", 32'(ferr_cnt - f0), 1);
    chk("t3_done", 32'(done_cnt - d0), 0);
    chk("t3_data", {24'd0, bus.o_data}, 32'h3C);
    chk("t3_busy", {31'd0, bus.o_busy}, 0);
    snap();
    send_frame(8'h81, 1'b1, 1'b0);
    idle(16);
    chk_frame("t3b", 8'h81);

    // 4: back-to-back 0x00, 0xFF
    snap();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(16);
    chk("t4_done", 32'(done_cnt - d0), 2);
    chk("t4_first", {24'd0, done_data[d0]}, 32'h00);
    chk("t4_second", {24'd0, done_data[d0 + 1]}, 32'hFF);
    chk("t4_ferr", 32'(ferr_cnt - f0), 0);

    // 5: async reset in the middle of bit 3, then 0x7E
    snap();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    bus.i_rx = 1'b0;
    repeat (32) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_data", {24'd0, bus.o_data}, 0);
    chk("t5_rst_busy", {31'd0, bus.o_busy}, 0);
    chk("t5_rst_done", {31'd0, bus.o_rx_done}, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    idle(2 * BIT_CLKS);
    chk("t5_no_pulse", 32'(done_cnt - d0 + ferr_cnt - f0), 0);
    snap();
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(16);
    chk_frame("t5", 8'h7E);

`ifdef UART_RX_PARITY_EN
    // 6: good parity then bad parity on 0x03
    snap();
    send_frame(8'h03, 1'b1, 1'b0);
    idle(16);
    chk_frame("t6a", 8'h03);
    chk("t6a_perr", 32'(perr_cnt - p0), 0);
    snap();
    send_frame(8'h03, 1'b1, 1'b1);
    idle(16);
    chk("t6b_perr", 32'(perr_cnt - p0), 1);
    chk("t6b_done", 32'(done_cnt - d0), 0);
    chk("t6b_data", {24'd0, bus.o_data}, 32'h03);
`else
    chk("perr_tied", 32'(perr_cnt), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
